// File: rtl/load_store_unit.sv
// Memory-access stage: one data-memory request per start over req/ack,
// with byte lane steering, load extension, alignment checks and timeout.
// Ports: clk, rst (async active-low); start/mem_read/mem_write/funct3/
// alu_result/store_data in; busy/done/fault/load_data out; mem_* bus.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RETIRE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic        fault_q, fault_d;
  logic [31:0] load_q, load_d;

  logic        bad;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign off = alu_result[1:0];

  // Illegal size or misalignment; only matters when an access is requested.
  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      funct3 == 3'd0: bad = 1'b0;
      funct3 == 3'd1: bad = off[0];
      funct3 == 3'd2: bad = |off;
      funct3 == 3'd4: bad = mem_write;
      funct3 == 3'd5: bad = mem_write | off[0];
      default:        bad = 1'b1;
    endcase
    if (mem_read && mem_write) bad = 1'b1;
  end

  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext = shifted;
    unique case (1'b1)
      f3_q == 3'd0: ext = {{24{shifted[7]}}, shifted[7:0]};
      f3_q == 3'd1: ext = {{16{shifted[15]}}, shifted[15:0]};
      f3_q == 3'd4: ext = {24'd0, shifted[7:0]};
      f3_q == 3'd5: ext = {16'd0, shifted[15:0]};
      default:      ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    f3_d    = f3_q;
    fault_d = fault_q;
    load_d  = load_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = alu_result;
          f3_d    = funct3;
          we_d    = mem_write & ~mem_read;
          cnt_d   = '0;
          wstrb_d = 4'b0000;
          fault_d = (mem_read | mem_write) & bad;
          if (mem_write && !bad) begin
            unique case (1'b1)
              funct3 == 3'd0: begin
                wdata_d = {4{store_data[7:0]}};
                wstrb_d = 4'b0001 << off;
              end
              funct3 == 3'd1: begin
                wdata_d = {2{store_data[15:0]}};
                wstrb_d = 4'b0011 << {off[1], 1'b0};
              end
              default: begin
                wdata_d = store_data;
                wstrb_d = 4'b1111;
              end
            endcase
          end
          if ((!mem_read && !mem_write) || bad) begin
            state_d = RETIRE;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!we_q) load_d = ext;
          state_d = RETIRE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = RETIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RETIRE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      fault_q <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      fault_q <= fault_d;
      load_q  <= load_d;
    end
  end

  assign mem_req   = (state_q == ACCESS);
  assign busy      = (state_q == ACCESS);
  assign done      = (state_q == RETIRE);
  assign fault     = (state_q == RETIRE) & fault_q;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign load_data = load_q;

endmodule
